// File: rtl/core_pkg.sv
// Shared types and helpers for the OBI memory responder.
//   obi_resp_t : one buffered response beat {rdata, err}
//   safe_clog2 : index width that never collapses to zero bits
package core_pkg;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } obi_resp_t;

   localparam int unsigned GntWaitMax = 15;

   // $clog2(1) is 0, which would give zero-width vectors.
   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// Response FIFO for obi_mem_responder. Holds obi_resp_t beats in order.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_push/i_data : write one entry (never while full)
//   i_pop         : drop the head entry (never while empty)
//   o_data        : head entry, valid when !o_empty
//   o_empty/o_full/o_count : occupancy status
module obi_resp_fifo
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PtrW = safe_clog2(DEPTH),
   localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_push,
   input  obi_resp_t       i_data,
   input  logic            i_pop,
   output obi_resp_t       o_data,
   output logic            o_empty,
   output logic            o_full,
   output logic [CntW-1:0] o_count
);

   obi_resp_t       r_mem [DEPTH];
   logic [PtrW-1:0] r_wptr;
   logic [PtrW-1:0] r_rptr;
   logic [CntW-1:0] r_count;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= ptr_inc(r_wptr);
         if (i_pop)  r_rptr <= ptr_inc(r_rptr);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the head is only consumed while non-empty.
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end

   assign o_data  = r_mem[r_rptr];
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CntW'(DEPTH));
   assign o_count = r_count;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI subordinate serving requests from an internal word-addressed SRAM.
// Optional grant wait-states, byte-enabled writes, registered reads and
// in-order responses buffered so the initiator can stall with rready.
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   obi_req_i/obi_gnt_o  : address-phase handshake
//   obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i : request payload
//   obi_rvalid_o/obi_rready_i : response handshake
//   obi_rdata_o, obi_err_o    : response payload
module obi_mem_responder
   import core_pkg::*;
#(
   parameter int unsigned MEM_WORDS  = 1024,
   parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
   parameter int unsigned GNT_WAIT   = 0,
   parameter int unsigned RESP_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        obi_req_i,
   output logic        obi_gnt_o,
   input  logic [31:0] obi_addr_i,
   input  logic        obi_we_i,
   input  logic [3:0]  obi_be_i,
   input  logic [31:0] obi_wdata_i,
   output logic        obi_rvalid_o,
   input  logic        obi_rready_i,
   output logic [31:0] obi_rdata_o,
   output logic        obi_err_o
);

   localparam int unsigned IdxW = safe_clog2(MEM_WORDS);
   localparam int unsigned OutW = $clog2(RESP_DEPTH + 1);

   logic [3:0]      r_wait_cnt;
   logic [OutW-1:0] r_outstanding;
   logic [31:0]     r_mem [MEM_WORDS];
   logic [31:0]     r_sram_q;
   logic            r_p1_valid;
   logic            r_p1_err;
   logic            r_p1_read;

   logic            w_accept;
   logic [31:0]     w_offset;
   logic [IdxW-1:0] w_idx;
   logic            w_addr_err;
   logic            w_mem_write;
   logic            w_mem_read;
   logic            w_retire;
   logic            w_p1_consume;
   logic            w_fifo_push;
   logic            w_fifo_pop;
   logic            w_fifo_empty;
   logic            w_fifo_full;
   logic [OutW-1:0] w_fifo_count;
   obi_resp_t       w_p1_resp;
   obi_resp_t       w_fifo_head;
   obi_resp_t       w_resp;

   // ---------------------------------------------------------------- grant
   assign obi_gnt_o = obi_req_i && (r_wait_cnt == 4'(GNT_WAIT))
                      && (r_outstanding < OutW'(RESP_DEPTH));
   assign w_accept  = obi_req_i && obi_gnt_o;

   // --------------------------------------------------------------- decode
   assign w_offset   = obi_addr_i - ADDR_BASE;
   assign w_idx      = w_offset[IdxW+1:2];
   assign w_addr_err = (obi_addr_i[1:0] != 2'b00) || (obi_addr_i < ADDR_BASE)
                       || ({2'b00, w_offset[31:2]} >= MEM_WORDS);
   assign w_mem_write = w_accept && obi_we_i && !w_addr_err;
   assign w_mem_read  = w_accept && !obi_we_i && !w_addr_err;

   // ----------------------------------------------------------------- SRAM
   // Contents survive reset; only the control path is cleared.
   always_ff @(posedge clk_i) begin
      if (w_mem_write) begin
         for (int k = 0; k < 4; k++) begin
            if (obi_be_i[k]) r_mem[w_idx][8*k +: 8] <= obi_wdata_i[8*k +: 8];
         end
      end
      if (w_mem_read) r_sram_q <= r_mem[w_idx];
   end

   // ------------------------------------------------------- response path
   // P1 is either retired directly or moved into the FIFO every cycle, so it
   // can always be overwritten by the next acceptance.
   assign w_p1_resp.rdata = r_p1_read ? r_sram_q : 32'h0;
   assign w_p1_resp.err   = r_p1_err;

   assign w_resp       = w_fifo_empty ? w_p1_resp : w_fifo_head;
   assign obi_rvalid_o = !w_fifo_empty || r_p1_valid;
   assign obi_rdata_o  = w_resp.rdata;
   assign obi_err_o    = w_resp.err;

   assign w_retire     = obi_rvalid_o && obi_rready_i;
   assign w_fifo_pop   = w_retire && !w_fifo_empty;
   assign w_p1_consume = w_retire && w_fifo_empty;
   assign w_fifo_push  = r_p1_valid && !w_p1_consume;

   obi_resp_fifo #(
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (w_fifo_push),
      .i_data  (w_p1_resp),
      .i_pop   (w_fifo_pop),
      .o_data  (w_fifo_head),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full),
      .o_count (w_fifo_count)
   );

   // --------------------------------------------------------- control regs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wait_cnt    <= '0;
         r_outstanding <= '0;
         r_p1_valid    <= 1'b0;
         r_p1_err      <= 1'b0;
         r_p1_read     <= 1'b0;
      end else begin
         if (!obi_req_i || w_accept) begin
            r_wait_cnt <= '0;
         end else if (r_wait_cnt < 4'(GNT_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end

         case ({w_accept, w_retire})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase

         r_p1_valid <= w_accept;
         r_p1_err   <= w_accept && w_addr_err;
         r_p1_read  <= w_mem_read;
      end
   end

   // Status outputs of the FIFO are only needed by the checks below.
   logic w_unused_fifo;
   assign w_unused_fifo = ^{w_fifo_full, w_fifo_count};

`ifdef SVA_ON
   a_no_idle_retire : assert property (@(posedge clk_i) disable iff (rst_i)
      !obi_rvalid_o |-> !w_fifo_pop && !w_p1_consume);
   a_out_bound : assert property (@(posedge clk_i) disable iff (rst_i)
      r_outstanding <= OutW'(RESP_DEPTH));
   a_resp_hold : assert property (@(posedge clk_i) disable iff (rst_i)
      obi_rvalid_o && !obi_rready_i |=>
         obi_rvalid_o && $stable(obi_rdata_o) && $stable(obi_err_o));
   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_fifo_push && w_fifo_full));
`endif

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench for obi_mem_responder: the driver pushes the expected
// response when a request is granted, an independent monitor pops and compares
// on every retire. A second instance with GNT_WAIT=3 checks grant timing.
module tb_obi_mem_responder;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, gnt, we, rvalid, rready, err;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;

   logic        w_req, w_gnt, w_rvalid, w_rready, w_err;
   logic [31:0] w_rdata_unused;

   int n_checks = 0;
   int n_fail   = 0;
   obi_resp_t sb_q[$];

   always #5 clk = ~clk;

   obi_mem_responder #(
      .MEM_WORDS  (1024),
      .ADDR_BASE  (32'h0000_0000),
      .GNT_WAIT   (0),
      .RESP_DEPTH (2)
   ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .obi_req_i    (req),
      .obi_gnt_o    (gnt),
      .obi_addr_i   (addr),
      .obi_we_i     (we),
      .obi_be_i     (be),
      .obi_wdata_i  (wdata),
      .obi_rvalid_o (rvalid),
      .obi_rready_i (rready),
      .obi_rdata_o  (rdata),
      .obi_err_o    (err)
   );

   obi_mem_responder #(
      .MEM_WORDS  (1024),
      .ADDR_BASE  (32'h0000_0000),
      .GNT_WAIT   (3),
      .RESP_DEPTH (2)
   ) u_dut_wait (
      .clk_i        (clk),
      .rst_i        (rst),
      .obi_req_i    (w_req),
      .obi_gnt_o    (w_gnt),
      .obi_addr_i   (32'h0000_0020),
      .obi_we_i     (1'b0),
      .obi_be_i     (4'hF),
      .obi_wdata_i  (32'h0),
      .obi_rvalid_o (w_rvalid),
      .obi_rready_i (w_rready),
      .obi_rdata_o  (w_rdata_unused),
      .obi_err_o    (w_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Call at posedge+1. Holds the request until granted, then drops req.
   task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                        input bit lat_chk = 1'b0);
      bit got = 1'b0;
      req = 1'b1; addr = a; we = w; be = b; wdata = d;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (lat_chk && i == 0) chk("latency_prev", rvalid, 1);
         if (gnt) begin
            got = 1'b1;
            sb_q.push_back('{rdata: exp_d, err: exp_e});
         end
         @(posedge clk); #1;
      end
      req = 1'b0;
      if (!got) chk("gnt_timeout", got, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin @(posedge clk); #1; end
      chk("drain", sb_q.size(), 0);
   endtask

   // Monitor: compare every retired response, and check the hold rules.
   logic [31:0] prev_rdata;
   logic        prev_err;
   bit          prev_stall = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_rvalid", rvalid, 1);
            chk("stall_rdata", rdata, prev_rdata);
            chk("stall_err", err, prev_err);
         end
         prev_stall <= rvalid && !rready;
         prev_rdata <= rdata;
         prev_err   <= err;
         if (rvalid && rready) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response",
                        rdata, err);
            end else begin
               obi_resp_t e;
               e = sb_q.pop_front();
               chk("rsp_rdata", rdata, e.rdata);
               chk("rsp_err", err, e.err);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   logic [31:0] stall_addr [4];
   logic [31:0] stall_data [4];

   initial begin
      int grants;
      int idx;
      int first;
      rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; rready = 1'b0;
      w_req = 1'b0; w_rready = 1'b1;
      stall_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
      stall_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_gnt", gnt, 0);
      chk("reset_rvalid", rvalid, 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_err", err, 0);
      rst = 1'b0;
      rready = 1'b1;
      idle(1);

      // Write then back-to-back read of the same word.
      issue(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
      issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      @(negedge clk); chk("latency_read", rvalid, 1);
      @(posedge clk); #1;

      // Single-byte write merges into the existing word.
      issue(32'h10, 1'b1, 4'b0010, 32'h0000_5500, 32'h0, 1'b0);
      issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAD_55EF, 1'b0);
      // be=0 writes nothing.
      issue(32'h10, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAD_55EF, 1'b0);
      // Misaligned and out-of-range accesses error and touch nothing.
      issue(32'h3, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
      issue(32'h1000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
      issue(32'h1000, 1'b1, 4'hF, 32'h1234_5678, 32'h0, 1'b1);
      issue(32'h12, 1'b1, 4'hF, 32'h1234_5678, 32'h0, 1'b1);
      issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAD_55EF, 1'b0);
      // Last word of the array.
      issue(32'hFFC, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
      issue(32'hFFC, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0);
      for (int i = 0; i < 4; i++) issue(stall_addr[i], 1'b1, 4'hF, stall_data[i], 32'h0, 1'b0);
      drain();

      // Credit limit with rready low: only two grants.
      rready = 1'b0;
      grants = 0;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         req = 1'b1; we = 1'b0; be = 4'hF; addr = stall_addr[idx];
         @(negedge clk);
         if (gnt) begin
            sb_q.push_back('{rdata: stall_data[idx], err: 1'b0});
            grants++;
            idx++;
         end
         @(posedge clk); #1;
      end
      chk("stall_grants", grants, 2);
      chk("stall_gnt_low", gnt, 0);
      rready = 1'b1;
      for (int c = 0; c < 40 && idx < 4; c++) begin
         req = 1'b1; addr = stall_addr[idx];
         @(negedge clk);
         if (gnt) begin
            sb_q.push_back('{rdata: stall_data[idx], err: 1'b0});
            idx++;
         end
         @(posedge clk); #1;
      end
      req = 1'b0;
      chk("stall_total", idx, 4);
      drain();

      // Reset with two responses pending.
      rready = 1'b0;
      issue(32'h0, 1'b0, 4'hF, 32'h0, 32'h1111_1111, 1'b0);
      issue(32'h4, 1'b0, 4'hF, 32'h0, 32'h2222_2222, 1'b0);
      chk("pre_rst_rvalid", rvalid, 1);
      rst = 1'b1;
      #1;
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      sb_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      rready = 1'b1;
      idle(1);
      issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAD_55EF, 1'b0);
      issue(32'h4, 1'b0, 4'hF, 32'h0, 32'h2222_2222, 1'b0);
      drain();

      // GNT_WAIT=3 instance: grant three cycles after req rises.
      first = -1;
      w_req = 1'b1;
      for (int k = 0; k < 10 && first < 0; k++) begin
         @(negedge clk);
         if (w_gnt) first = k;
         @(posedge clk); #1;
      end
      w_req = 1'b0;
      chk("wait_first_gnt", first, 3);
      @(negedge clk);
      chk("wait_rvalid", w_rvalid, 1);
      chk("wait_err", w_err, 0);
      @(posedge clk); #1;

      chk("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
